// File: rtl/spi_ram_pkg.sv
// spi_ram_pkg: shared constants for the SPI RAM controller.
//   OP_*   : 2-bit opcodes carried in din[9:8]
//   CMD_W  : width of the command word from the SPI slave
// Optional build macro SPI_RAM_AUTOINC_EN (used in spi_ram_ctrl) enables
// post-access address auto-increment.
package spi_ram_pkg;

  localparam int CMD_W = 10;

  typedef enum logic [1:0] {
    OP_WR_ADDR = 2'b00,
    OP_WR_DATA = 2'b01,
    OP_RD_ADDR = 2'b10,
    OP_RD_DATA = 2'b11
  } op_e;

endpackage

// File: rtl/spi_ram_ctrl_if.sv
// spi_ram_ctrl_if: command/response bundle between an SPI slave front end
// and the RAM controller.
//   din[9:0]  : command word (opcode in 9:8, payload in 7:0)
//   rx_valid  : din valid this cycle
//   dout[7:0] : read data returned for MISO shifting
//   tx_valid  : dout valid, held for the whole shift
// Modports: master = SPI slave side (drives commands), slave = controller.
interface spi_ram_ctrl_if;
  import spi_ram_pkg::*;

  logic [CMD_W-1:0] din;
  logic             rx_valid;
  logic [7:0]       dout;
  logic             tx_valid;

  modport master (output din, rx_valid, input dout, tx_valid);
  modport slave  (input din, rx_valid, output dout, tx_valid);
endinterface

// File: rtl/spram_core.sv
// spram_core: single-port byte RAM with registered read.
//   clk   : rising-edge clock
//   we    : write enable; when low the addressed word is read instead
//   addr  : word address
//   wdata : write data
//   rdata : read data, registered; only updated on non-write cycles
// Contents are not reset.
module spram_core #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];
  logic [7:0] rdata_q;

  // One access per cycle: a write or a read, never both.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    else    rdata_q   <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/spi_ram_ctrl.sv
// spi_ram_ctrl: decodes 10-bit SPI command words into accesses of a
// single-port byte RAM and returns read data with a level tx_valid.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset (RAM contents survive it)
//   bus   : spi_ram_ctrl_if.slave (din, rx_valid in; dout, tx_valid out)
// Build macro SPI_RAM_AUTOINC_EN: WR_DATA / RD_DATA post-increment their
// address register, wrapping modulo MEM_DEPTH.
module spi_ram_ctrl
  import spi_ram_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  spi_ram_ctrl_if.slave      bus
);

  logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
  logic                 tx_valid_q, tx_valid_d;
  logic                 rd_fresh_q, rd_fresh_d;
  logic [7:0]           dout_hold_q, dout_hold_d;

  logic                 mem_we;
  logic [ADDR_SIZE-1:0] mem_addr;
  logic [7:0]           mem_rdata;
  op_e                  op;

  assign op = op_e'(bus.din[9:8]);

`ifdef SPI_RAM_AUTOINC_EN
  function automatic logic [ADDR_SIZE-1:0] addr_inc(input logic [ADDR_SIZE-1:0] a);
    return (a == ADDR_SIZE'(MEM_DEPTH - 1)) ? '0 : a + 1'b1;
  endfunction
`endif

  // Idle cycles still read the RAM at rd_addr; that rdata never reaches dout
  // unless an RD_DATA was accepted on the previous edge.
  assign mem_we   = bus.rx_valid && (op == OP_WR_DATA);
  assign mem_addr = mem_we ? wr_addr_q : rd_addr_q;

  spram_core #(
    .DEPTH (MEM_DEPTH),
    .AW    (ADDR_SIZE)
  ) u_core (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (bus.din[7:0]),
    .rdata (mem_rdata)
  );

  always_comb begin
    wr_addr_d   = wr_addr_q;
    rd_addr_d   = rd_addr_q;
    tx_valid_d  = tx_valid_q;
    rd_fresh_d  = 1'b0;
    // Freeze the RAM output the cycle after a read so later RAM traffic
    // (including writes to rd_addr) cannot disturb dout.
    dout_hold_d = rd_fresh_q ? mem_rdata : dout_hold_q;

    if (bus.rx_valid) begin
      case (op)
        OP_WR_ADDR: begin
          wr_addr_d  = bus.din[ADDR_SIZE-1:0];
          tx_valid_d = 1'b0;
        end
        OP_WR_DATA: begin
          tx_valid_d = 1'b0;
`ifdef SPI_RAM_AUTOINC_EN
          wr_addr_d  = addr_inc(wr_addr_q);
`endif
        end
        OP_RD_ADDR: begin
          rd_addr_d  = bus.din[ADDR_SIZE-1:0];
          tx_valid_d = 1'b0;
        end
        OP_RD_DATA: begin
          tx_valid_d = 1'b1;
          rd_fresh_d = 1'b1;
`ifdef SPI_RAM_AUTOINC_EN
          rd_addr_d  = addr_inc(rd_addr_q);
`endif
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_addr_q   <= '0;
      rd_addr_q   <= '0;
      tx_valid_q  <= 1'b0;
      rd_fresh_q  <= 1'b0;
      dout_hold_q <= 8'h00;
    end else begin
      wr_addr_q   <= wr_addr_d;
      rd_addr_q   <= rd_addr_d;
      tx_valid_q  <= tx_valid_d;
      rd_fresh_q  <= rd_fresh_d;
      dout_hold_q <= dout_hold_d;
    end
  end

  assign bus.dout     = rd_fresh_q ? mem_rdata : dout_hold_q;
  assign bus.tx_valid = tx_valid_q;

endmodule

// File: doc/spi_ram_ctrl.md
SPI_RAM_CTRL -- requirements
Module: spi_ram_ctrl

Interface
REQ-001 The block SHALL have parameter MEM_DEPTH, default 256: number of 8-bit words.
REQ-002 The block SHALL have parameter ADDR_SIZE, default 8: address width; log2(MEM_DEPTH), at most 8.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all logic on the rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port din, input, 10 bits: command word from the SPI slave; bits 9:8 are the opcode and bits 7:0 the payload.
REQ-006 The block SHALL have port rx_valid, input, 1 bit: din is valid this cycle.
REQ-007 The block SHALL have port dout, output, 8 bits: read data returned to the SPI slave.
REQ-008 The block SHALL have port tx_valid, output, 1 bit: dout is valid; level signal held for the whole MISO shift.

Function
REQ-009 The block SHALL execute one command per clk edge where rx_valid=1 and SHALL change no state when rx_valid=0.
REQ-010 Opcode 00 (WR_ADDR) SHALL load wr_addr with din[ADDR_SIZE-1:0].
REQ-011 Opcode 01 (WR_DATA) SHALL write din[7:0] to mem[wr_addr] on that edge.
REQ-012 Opcode 10 (RD_ADDR) SHALL load rd_addr with din[ADDR_SIZE-1:0].
REQ-013 Opcode 11 (RD_DATA) SHALL ignore the payload, register mem[rd_addr] into dout and set tx_valid, both visible one cycle after the accepting edge.
REQ-014 tx_valid SHALL stay high, with dout stable, until the next accepted command with opcode other than 11; that edge SHALL clear tx_valid.
REQ-015 Back-to-back RD_DATA commands SHALL keep tx_valid high and update dout on each command.
REQ-016 A WR_DATA to the address currently held in rd_addr SHALL NOT alter dout until the next RD_DATA.
REQ-017 Payload bits above ADDR_SIZE-1 SHALL be ignored for address opcodes.
REQ-018 The storage SHALL be single-port: one access per cycle, either a read or a write, never both.

Reset
REQ-019 On an edge with rst_n=0 the block SHALL set dout=8'h00, tx_valid=0, wr_addr=0 and rd_addr=0, taking precedence over rx_valid.
REQ-020 Memory contents SHALL NOT be cleared by reset.
REQ-021 A reset asserted while tx_valid is high SHALL drop tx_valid on that same edge.

Configuration
REQ-022 With macro SPI_RAM_AUTOINC_EN defined, each WR_DATA SHALL increment wr_addr and each RD_DATA SHALL increment rd_addr after the access.
REQ-023 Under SPI_RAM_AUTOINC_EN, both increments SHALL wrap modulo MEM_DEPTH (MEM_DEPTH-1 -> 0).
REQ-024 Without SPI_RAM_AUTOINC_EN, the address registers SHALL change only on WR_ADDR and RD_ADDR commands.

Structure
REQ-025 The shared package spi_ram_pkg SHALL hold the opcode constants OP_WR_ADDR=2'b00, OP_WR_DATA=2'b01, OP_RD_ADDR=2'b10 and OP_RD_DATA=2'b11, plus the command-word width constant (10).
REQ-026 The storage array SHALL be a sub-module spram_core with ports clk, we, addr, wdata and rdata, and a registered read.
REQ-027 Command decode, the address registers and tx_valid control SHALL reside in spi_ram_ctrl.

Verification
REQ-028 The bench SHALL cover a basic write and read: WR_ADDR 0x12, WR_DATA 0xA5, RD_ADDR 0x12, RD_DATA -> one cycle later dout=0xA5 and tx_valid=1.
REQ-029 The bench SHALL cover tx_valid hold and release: after the RD_DATA above, hold rx_valid=0 for 10 cycles -> tx_valid stays 1 and dout stays 0xA5; then WR_ADDR 0x00 -> tx_valid=0 on the next cycle.
REQ-030 The bench SHALL cover idle input: rx_valid=0 with din toggling randomly for 50 cycles -> no memory or address change and no tx_valid change.
REQ-031 The bench SHALL cover auto-increment with SPI_RAM_AUTOINC_EN: WR_ADDR 0xFF, then WR_DATA 0x11 and WR_DATA 0x22 -> mem[0xFF]=0x11 and mem[0x00]=0x22.
REQ-032 The bench SHALL cover auto-increment reads with SPI_RAM_AUTOINC_EN: RD_ADDR 0xFF, then RD_DATA twice -> dout=0x11 then 0x22.
REQ-033 The bench SHALL cover the same sequence without SPI_RAM_AUTOINC_EN -> mem[0xFF]=0x22 and mem[0x00] unchanged.
REQ-034 The bench SHALL cover reset mid-read: rst_n=0 for one cycle while tx_valid=1 -> dout=0x00 and tx_valid=0 next cycle, prior memory data intact, and RD_ADDR 0x12, RD_DATA still returns 0xA5.
